pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Central sequencing controller for the 5-stage ARM-subset pipeline, sitting beside the execute stage. It owns the architectural status register that feeds the execute ALU. It evaluates the condition code of the instruction in ID, detects RAW hazards against the EXE and MEM destinations, and generates stall, flush and memory-wait freeze. It also keeps a memory-wait timeout FSM and a saturating stall counter for debug.

## Interface
- TIMEOUT, 255: max consecutive memory-wait cycles before `mem_timeout` sets (1..2^CNT_W-1).
- CNT_W, 16: width of wait counter and stall counter.
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_cond  in  4  condition field of ID instruction.
- id_src1, id_src2  in  4  source register numbers (Rn, Rm/Rd).
- id_two_src  in  1  instruction reads id_src2.
- exe_wb_en, mem_wb_en  in  1  stage will write a register.
- exe_dest, mem_dest  in  4  destination register of that stage.
- exe_s  in  1  EXE instruction updates flags.
- exe_status_out  in  4  flags produced by the EXE ALU.
- exe_b  in  1  EXE holds a taken branch (already condition-qualified).
- mem_access  in  1  MEM stage is performing a load/store.
- mem_ready  in  1  memory completes the access this cycle.
- status  out  4  flag register {Z,C,N,V} (bit2 = C, drives ALU carry-in).
- cond_pass  out  1  ID condition satisfied by `status`.
- hazard_stall  out  1  hold PC and IF/ID, bubble into ID/EXE.
- flush  out  1  clear IF/ID and ID/EXE (branch taken).
- freeze  out  1  hold every pipeline register.
- mem_timeout  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  saturating count of stalled/frozen cycles.

## Operation
- freeze = mem_access & ~mem_ready (combinational). Freeze has top priority: while high, flush = 0, hazard_stall = 0, and status does not load.
- flush = exe_b & ~freeze.
- raw = id_valid & ((exe_wb_en & id_src1==exe_dest) | (mem_wb_en & id_src1==mem_dest) | (id_two_src & ((exe_wb_en & id_src2==exe_dest) | (mem_wb_en & id_src2==mem_dest)))).
- hazard_stall = raw & ~flush & ~freeze.
- Status register: at each edge, if exe_s & ~freeze, status <= exe_status_out; otherwise it holds.
- cond_pass decode of id_cond:
  - 0 EQ Z, 1 NE !Z, 2 CS C, 3 CC !C, 4 MI N, 5 PL !N, 6 VS V, 7 VC !V.
  - 8 HI C&!Z, 9 LS !C|Z, A GE N==V, B LT N!=V, C GT !Z&(N==V), D LE Z|(N!=V).
  - E AL 1, F 0.
- Memory FSM, states RUN and WAIT:
  - RUN→WAIT when freeze; wait_cnt <= 1.
  - WAIT: if mem_ready or ~mem_access → RUN, wait_cnt <= 0. Else wait_cnt increments, saturating at 2^CNT_W-1.
  - When wait_cnt reaches TIMEOUT in WAIT, mem_timeout <= 1 and stays set until rst. The FSM keeps waiting; it does not abort the access.
- stall_cnt increments at each edge where hazard_stall | freeze; saturates at all-ones.

## Timing
- Reset (async, immediate) sets:
  - status = 0, state RUN, wait_cnt = 0, mem_timeout = 0, stall_cnt = 0.
  - Combinational outputs then follow inputs: cond_pass = 1 for AL, EQ false, NE true.
- cond_pass, hazard_stall, flush, freeze are same-cycle combinational; no registered latency.
- Flag latency: exe_s in cycle n → new status visible to cond_pass and the ALU in cycle n+1.
- Simultaneous flush and raw: flush wins, hazard_stall = 0.
- Simultaneous freeze and exe_b: no flush that cycle; flush asserts in the first cycle freeze drops, provided exe_b is still held (frozen registers guarantee it).
- A single-cycle access with mem_ready high in the same cycle produces no freeze and no state change.
- Reset mid-WAIT returns to RUN with counters cleared, regardless of mem_access.

## Test plan
- Reset with id_cond=E, then id_cond=0 → status=0, cond_pass=1 then 0, all counters 0.
- exe_s=1, exe_status_out=4'b1000 for one cycle, then id_cond=0 → next cycle status=8, cond_pass=1; id_cond=1 → 0.
- id_valid, id_src1=3, exe_wb_en, exe_dest=3 → hazard_stall=1, stall_cnt increments. Add exe_b=1 → hazard_stall=0, flush=1. id_two_src=0 with only src2 matching → no stall.
- mem_access=1, mem_ready=0 for 4 cycles, then ready → freeze high 4 cycles, exe_s ignored during them, FSM back to RUN, stall_cnt=4.
- TIMEOUT=3, mem_ready held low for 6 cycles → mem_timeout rises when wait_cnt=3 and stays set after ready; clears only on rst.
- Assert rst during WAIT with stall_cnt=7 → immediate RUN, stall_cnt=0, mem_timeout=0.

Source files
------------

// File: rtl/pipe_ctrl_unit_if.sv
// Pipeline-control signal bundle between the datapath stages and pipe_ctrl_unit.
interface pipe_ctrl_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [3:0]       id_cond;
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_two_src;
  logic             exe_wb_en;
  logic             mem_wb_en;
  logic [3:0]       exe_dest;
  logic [3:0]       mem_dest;
  logic             exe_s;
  logic [3:0]       exe_status_out;
  logic             exe_b;
  logic             mem_access;
  logic             mem_ready;
  logic [3:0]       status;
  logic             cond_pass;
  logic             hazard_stall;
  logic             flush;
  logic             freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  id_valid, id_cond, id_src1, id_src2, id_two_src,
    input  exe_wb_en, mem_wb_en, exe_dest, mem_dest,
    input  exe_s, exe_status_out, exe_b, mem_access, mem_ready,
    output status, cond_pass, hazard_stall, flush, freeze, mem_timeout, stall_cnt
  );

  modport master (
    output id_valid, id_cond, id_src1, id_src2, id_two_src,
    output exe_wb_en, mem_wb_en, exe_dest, mem_dest,
    output exe_s, exe_status_out, exe_b, mem_access, mem_ready,
    input  status, cond_pass, hazard_stall, flush, freeze, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipeline sequencing controller: status flags, condition check, RAW stall,
// branch flush, memory-wait freeze with timeout FSM and debug stall counter.
module pipe_ctrl_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic clk,
  input  logic rst,
  pipe_ctrl_unit_if.slave bus
);
  typedef enum logic {S_RUN, S_WAIT} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;
  logic [3:0]       status_q, status_d;

  logic freeze, flush, raw, hazard_stall, cond_pass;
  logic z, c, n, v;

  assign {z, c, n, v} = status_q;

  always_comb begin
    freeze       = bus.mem_access & ~bus.mem_ready;
    flush        = bus.exe_b & ~freeze;
    raw          = bus.id_valid &
                   ((bus.exe_wb_en & (bus.id_src1 == bus.exe_dest)) |
                    (bus.mem_wb_en & (bus.id_src1 == bus.mem_dest)) |
                    (bus.id_two_src &
                     ((bus.exe_wb_en & (bus.id_src2 == bus.exe_dest)) |
                      (bus.mem_wb_en & (bus.id_src2 == bus.mem_dest)))));
    hazard_stall = raw & ~flush & ~freeze;
  end

  always_comb begin
    cond_pass = 1'b0;
    case (bus.id_cond)
      4'h0: cond_pass = z;
      4'h1: cond_pass = ~z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = ~c;
      4'h4: cond_pass = n;
      4'h5: cond_pass = ~n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = ~v;
      4'h8: cond_pass = c & ~z;
      4'h9: cond_pass = ~c | z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = ~z & (n == v);
      4'hD: cond_pass = z | (n != v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    status_d    = status_q;
    stall_cnt_d = stall_cnt_q;

    if (bus.exe_s && !freeze) status_d = bus.exe_status_out;
    if ((hazard_stall || freeze) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;

    case (state_q)
      S_RUN: begin
        if (freeze) begin
          state_d    = S_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (bus.mem_ready || !bus.mem_access) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else begin
          if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
          // Timeout only flags the condition; the access keeps waiting.
          if (wait_cnt_q >= TMO) timeout_d = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      status_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      status_q    <= status_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.status       = status_q;
  assign bus.cond_pass    = cond_pass;
  assign bus.hazard_stall = hazard_stall;
  assign bus.flush        = flush;
  assign bus.freeze       = freeze;
  assign bus.mem_timeout  = timeout_q;
  assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit (TIMEOUT=3, CNT_W=16).
module tb_pipe_ctrl_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.CNT_W(16)) bus ();

  pipe_ctrl_unit #(.TIMEOUT(3), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.id_valid = 0; bus.id_cond = 4'hE; bus.id_src1 = 0; bus.id_src2 = 0;
    bus.id_two_src = 0; bus.exe_wb_en = 0; bus.mem_wb_en = 0;
    bus.exe_dest = 0; bus.mem_dest = 0; bus.exe_s = 0; bus.exe_status_out = 0;
    bus.exe_b = 0; bus.mem_access = 0; bus.mem_ready = 0;

    // Reset state
    #2;
    chk("rst_status", 32'(bus.status), 0);
    chk("rst_al", 32'(bus.cond_pass), 1);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 0);
    chk("rst_timeout", 32'(bus.mem_timeout), 0);
    chk("rst_freeze", 32'(bus.freeze), 0);
    bus.id_cond = 4'h0; #1;
    chk("rst_eq", 32'(bus.cond_pass), 0);
    bus.id_cond = 4'h1; #1;
    chk("rst_ne", 32'(bus.cond_pass), 1);
    @(negedge clk); rst = 0;

    // Flag update with one-cycle latency
    edge1();
    bus.exe_s = 1; bus.exe_status_out = 4'b1000; bus.id_cond = 4'h0; #1;
    chk("eq_before_load", 32'(bus.cond_pass), 0);
    edge1();
    bus.exe_s = 0; #1;
    chk("status_loaded", 32'(bus.status), 8);
    chk("eq_after_load", 32'(bus.cond_pass), 1);
    bus.id_cond = 4'h1; #1; chk("ne_after_load", 32'(bus.cond_pass), 0);
    bus.id_cond = 4'hC; #1; chk("gt_z", 32'(bus.cond_pass), 0);
    bus.id_cond = 4'hD; #1; chk("le_z", 32'(bus.cond_pass), 1);
    bus.id_cond = 4'h9; #1; chk("ls_z", 32'(bus.cond_pass), 1);
    bus.id_cond = 4'hF; #1; chk("nv", 32'(bus.cond_pass), 0);

    // RAW hazard against EXE
    bus.id_valid = 1; bus.id_src1 = 3; bus.exe_wb_en = 1; bus.exe_dest = 3; #1;
    chk("raw_exe_stall", 32'(bus.hazard_stall), 1);
    chk("raw_exe_flush", 32'(bus.flush), 0);
    edge1();
    chk("stall_cnt_1", 32'(bus.stall_cnt), 1);
    bus.exe_b = 1; #1;
    chk("flush_wins_stall", 32'(bus.hazard_stall), 0);
    chk("flush_wins_flush", 32'(bus.flush), 1);
    edge1();
    chk("stall_cnt_flush", 32'(bus.stall_cnt), 1);
    bus.exe_b = 0; bus.id_src1 = 5; bus.id_src2 = 3; bus.id_two_src = 0; #1;
    chk("src2_ignored", 32'(bus.hazard_stall), 0);
    bus.id_two_src = 1; #1;
    chk("src2_exe", 32'(bus.hazard_stall), 1);
    bus.exe_wb_en = 0; #1;
    chk("src2_no_wb", 32'(bus.hazard_stall), 0);
    bus.mem_wb_en = 1; bus.mem_dest = 3; #1;
    chk("src2_mem", 32'(bus.hazard_stall), 1);
    bus.id_valid = 0; #1;
    chk("invalid_no_stall", 32'(bus.hazard_stall), 0);
    bus.mem_wb_en = 0; bus.id_two_src = 0;

    // Memory freeze for 4 cycles; flags and branch held off
    bus.mem_access = 1; bus.mem_ready = 0; bus.exe_s = 1; bus.exe_status_out = 4'b0100;
    bus.exe_b = 1; #1;
    chk("freeze_on", 32'(bus.freeze), 1);
    chk("freeze_no_flush", 32'(bus.flush), 0);
    for (int k = 1; k <= 4; k++) begin
      edge1();
      chk("freeze_stall_cnt", 32'(bus.stall_cnt), 32'(1 + k));
      chk("freeze_status_hold", 32'(bus.status), 8);
      chk("freeze_timeout", 32'(bus.mem_timeout), (k == 4) ? 1 : 0);
    end
    bus.mem_ready = 1; bus.exe_s = 0; #1;
    chk("ready_unfreeze", 32'(bus.freeze), 0);
    chk("ready_flush", 32'(bus.flush), 1);
    edge1();
    bus.exe_b = 0; bus.mem_access = 0; bus.mem_ready = 0; #1;
    chk("after_ready_cnt", 32'(bus.stall_cnt), 5);
    chk("after_ready_status", 32'(bus.status), 8);
    chk("timeout_sticky", 32'(bus.mem_timeout), 1);

    // Reset in the middle of WAIT
    bus.mem_access = 1;
    edge1(); edge1();
    chk("pre_rst_cnt", 32'(bus.stall_cnt), 7);
    #2; rst = 1; #1;
    chk("midwait_rst_cnt", 32'(bus.stall_cnt), 0);
    chk("midwait_rst_timeout", 32'(bus.mem_timeout), 0);
    chk("midwait_rst_status", 32'(bus.status), 0);
    @(negedge clk); bus.mem_access = 0; rst = 0;

    // Timeout after 3 wait cycles with a 6-cycle wait
    edge1();
    bus.mem_access = 1; bus.mem_ready = 0;
    for (int k = 1; k <= 6; k++) begin
      edge1();
      chk("tmo_flag", 32'(bus.mem_timeout), (k >= 4) ? 1 : 0);
    end
    chk("tmo_stall_cnt", 32'(bus.stall_cnt), 6);
    bus.mem_ready = 1;
    edge1();
    chk("tmo_after_ready", 32'(bus.mem_timeout), 1);
    chk("tmo_cnt_ready", 32'(bus.stall_cnt), 6);

    // Single-cycle access: no freeze, nothing counted
    #1;
    chk("single_no_freeze", 32'(bus.freeze), 0);
    edge1();
    bus.mem_access = 0; bus.mem_ready = 0;
    edge1();
    chk("single_cnt", 32'(bus.stall_cnt), 6);

    // Fresh freeze after return to RUN counts again
    bus.mem_access = 1;
    edge1();
    chk("rerun_cnt", 32'(bus.stall_cnt), 7);
    bus.mem_access = 0;
    edge1();
    chk("rerun_timeout", 32'(bus.mem_timeout), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
